rtl_job_scheduler: RTL and testbench

//  Shares one Design_Example_RTL instance (Start/A/E/F counter datapath) among NUM_REQ requesters.

---
 rtl/job_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/rtl_job_scheduler.sv | 139 +++++++++++++
 tb/tb_rtl_job_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/job_sched_pkg.sv
// Shared types and helpers for the job scheduler: FSM encoding, result payload, index width.
package job_sched_pkg;

  localparam int unsigned NUM_REQ_MAX = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b11,
    S_DONE  = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic       e;
  } job_result_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from rr_ptr+1.
module rr_arbiter
  import job_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant_nxt_c,
  output logic [IW-1:0]      index_c,
  output logic               found_c
);

  int unsigned j;

  always_comb begin
    j       = 0;
    found_c = 1'b0;
    index_c = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      j = (32'(rr_ptr) + i) % NUM_REQ;
      if (!found_c && req[IW'(j)]) begin
        found_c = 1'b1;
        index_c = IW'(j);
      end
    end
    grant_nxt_c = found_c ? (NUM_REQ'(1) << index_c) : '0;
  end

endmodule

// File: rtl/rtl_job_scheduler.sv
// Round-robin job scheduler sharing one Start/A/E/F datapath among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining JOB_SCHED_TIMEOUT_EN.
module rtl_job_scheduler
  import job_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               done,
  output logic [3:0]         result_a,
  output logic               result_e,
  output logic               err,
  output logic               busy,
  output logic               dp_start,
  input  logic [3:0]         dp_a,
  input  logic               dp_e,
  input  logic               dp_f
);

  localparam int unsigned IW = clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt, gnt_idx, gnt_idx_nxt, arb_idx;
  logic [NUM_REQ-1:0] arb_grant, grant_nxt;
  logic               arb_found;
  logic               done_nxt, err_nxt, busy_nxt, dp_start_nxt;
  job_result_t        res, res_nxt;
  logic               wd_expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant_nxt_c (arb_grant),
    .index_c     (arb_idx),
    .found_c     (arb_found)
  );

`ifdef JOB_SCHED_TIMEOUT_EN
  // Watchdog: cleared while issuing, counts every WAIT cycle.
  logic [5:0] wd_cnt, wd_cnt_nxt;

  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (state == S_ISSUE) wd_cnt_nxt = '0;
    else if (state == S_WAIT) wd_cnt_nxt = wd_cnt + 6'd1;
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) wd_cnt <= '0;
    else          wd_cnt <= wd_cnt_nxt;
  end

  assign wd_expired = (state == S_WAIT) && (wd_cnt == 6'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYC);
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arb_found) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (dp_f || wd_expired) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; dp_f is only looked at in WAIT.
  always_comb begin
    grant_nxt    = grant;
    gnt_idx_nxt  = gnt_idx;
    rr_ptr_nxt   = rr_ptr;
    res_nxt      = res;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    dp_start_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_found) begin
          grant_nxt    = arb_grant;
          gnt_idx_nxt  = arb_idx;
          dp_start_nxt = 1'b1;
        end
      end
      S_ISSUE: rr_ptr_nxt = gnt_idx;
      S_WAIT: begin
        if (dp_f) begin
          res_nxt  = '{a: dp_a, e: dp_e};
          done_nxt = 1'b1;
        end else if (wd_expired) begin
          res_nxt  = '0;
          done_nxt = 1'b1;
          err_nxt  = 1'b1;
        end
      end
      S_DONE:  grant_nxt = '0;
      default: grant_nxt = '0;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      grant    <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= IW'(NUM_REQ - 1);
      res      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      dp_start <= 1'b0;
    end else begin
      grant    <= grant_nxt;
      gnt_idx  <= gnt_idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      res      <= res_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      dp_start <= dp_start_nxt;
    end
  end

  assign result_a = res.a;
  assign result_e = res.e;

endmodule

// File: tb/tb_rtl_job_scheduler.sv
// Scoreboard bench for rtl_job_scheduler with a behavioural Start/A/E/F datapath.
module tb_rtl_job_scheduler;

  logic       clock = 1'b0;
  logic       reset_b = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       done, result_e, err, busy, dp_start;
  logic [3:0] result_a;
  logic       kill_f = 1'b0;

  // Datapath model: Start clears A/E/F; A counts so F and A=13 appear 14 cycles after Start's cycle.
  logic [3:0] m_a = 4'd0;
  logic       m_e = 1'b0, m_f = 1'b0, m_run = 1'b0;
  logic       dp_f_in;

  assign dp_f_in = m_f & ~kill_f;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (dp_start) begin
      m_a <= 4'd0; m_e <= 1'b0; m_f <= 1'b0; m_run <= 1'b1;
    end else if (m_run) begin
      if (m_a == 4'd12) begin
        m_f <= 1'b1; m_e <= 1'b1; m_run <= 1'b0;
      end
      m_a <= m_a + 4'd1;
    end
  end

  rtl_job_scheduler #(.NUM_REQ(4), .TIMEOUT_CYC(32)) dut (
    .clock    (clock),
    .reset_b  (reset_b),
    .req      (req),
    .grant    (grant),
    .done     (done),
    .result_a (result_a),
    .result_e (result_e),
    .err      (err),
    .busy     (busy),
    .dp_start (dp_start),
    .dp_a     (m_a),
    .dp_e     (m_e),
    .dp_f     (dp_f_in)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] a;
    logic       e;
    logic       err;
    logic [7:0] lat;
    logic [7:0] gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  int   last_done = 0;
  logic prev_start = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each done and checks issue-side timing.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_b) begin
      prev_start = 1'b0;
    end else begin
      if (prev_start) chk("dp_start_one_cycle", int'(dp_start), 0);
      if (dp_start) begin
        issue_cyc = cyc;
        if (q.size() > 0) begin
          chk("issue_grant", int'(grant), int'(q[0].grant));
          if (q[0].gap != 8'd0) chk("issue_gap", cyc - last_done, int'(q[0].gap));
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual grant %b required no done", grant);
        end else begin
          e = q.pop_front();
          chk("done_grant", int'(grant), int'(e.grant));
          chk("result_a", int'(result_a), int'(e.a));
          chk("result_e", int'(result_e), int'(e.e));
          chk("err", int'(err), int'(e.err));
          chk("latency", cyc - issue_cyc, int'(e.lat));
        end
        last_done = cyc;
      end
      prev_start = dp_start;
    end
  end

  task automatic check_zero(input string name);
    chk(name, int'({grant, done, err, busy, dp_start, result_a, result_e}), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_b = 1'b0;
    req     = 4'b0000;
    repeat (2) @(negedge clock);
    check_zero("reset_outputs");
    reset_b = 1'b1;
  endtask

  task automatic wait_start();
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (dp_start) return;
    end
    chk("wait_start_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (q.size() == 0 && !busy) return;
    end
    chk("wait_idle_timeout", int'(q.size()), 0);
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [3:0] a, input logic e,
                              input logic er, input int lat, input int gap);
    mk = '{grant: g, a: a, e: e, err: er, lat: 8'(lat), gap: 8'(gap)};
  endfunction

  initial begin
    // Single requester from reset.
    do_reset();
    q.push_back(mk(4'b0100, 4'd13, 1'b1, 1'b0, 15, 0));
    req = 4'b0100;
    wait_start();
    req = 4'b0000;
    wait_idle();

    // All requesting: rotation from reset, one IDLE cycle between jobs, stale F at each issue.
    do_reset();
    q.push_back(mk(4'b0001, 4'd13, 1'b1, 1'b0, 15, 0));
    q.push_back(mk(4'b0010, 4'd13, 1'b1, 1'b0, 15, 2));
    q.push_back(mk(4'b0100, 4'd13, 1'b1, 1'b0, 15, 2));
    q.push_back(mk(4'b1000, 4'd13, 1'b1, 1'b0, 15, 2));
    q.push_back(mk(4'b0001, 4'd13, 1'b1, 1'b0, 15, 2));
    req = 4'b1111;
    repeat (5) wait_start();
    req = 4'b0000;
    wait_idle();

    // req[1] pulses one cycle; req[3] arrives mid-job and waits for IDLE.
    q.push_back(mk(4'b0010, 4'd13, 1'b1, 1'b0, 15, 0));
    q.push_back(mk(4'b1000, 4'd13, 1'b1, 1'b0, 15, 2));
    req = 4'b0010;
    @(negedge clock);
    req = 4'b0000;
    repeat (5) @(negedge clock);
    req = 4'b1000;
    wait_start();
    req = 4'b0000;
    wait_idle();

    // Reset in WAIT cycle 6, then a normal job.
    req = 4'b0001;
    wait_start();
    req = 4'b0000;
    repeat (6) @(negedge clock);
    reset_b = 1'b0;
    @(negedge clock);
    check_zero("midjob_reset_outputs");
    reset_b = 1'b1;
    q.push_back(mk(4'b0001, 4'd13, 1'b1, 1'b0, 15, 0));
    req = 4'b0001;
    wait_start();
    req = 4'b0000;
    wait_idle();

`ifdef JOB_SCHED_TIMEOUT_EN
    // F never arrives: watchdog ends the job after 32 WAIT cycles.
    kill_f = 1'b1;
    q.push_back(mk(4'b0001, 4'd0, 1'b0, 1'b1, 33, 0));
    req = 4'b0001;
    wait_start();
    req = 4'b0000;
    wait_idle();
    kill_f = 1'b0;
`endif

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", int'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "simulation time limit");
  end

endmodule
